// File: rtl/uart_number_rx_pkg.sv
// Shared definitions for the serial number receiver: byte FSM encoding,
// ASCII constants used by the digit assembler, and the bit-period helper.
package uart_number_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    // Number of clk cycles per serial bit; callers guarantee the result is >= 8.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_number_rx_if.sv
// Output bundle of the number receiver.
// Handshake: rx_valid, frame_err and number_valid are single-cycle strobes
// with no back-pressure; rx_data and number are stable whenever their strobe
// is low and update on the same clock edge that raises the strobe.
interface uart_number_rx_if
    import uart_number_rx_pkg::*;
#(
    parameter int NUMBER_W = 16
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                frame_err;
    logic [NUMBER_W-1:0] number;
    logic                number_valid;
    rx_state_t           state;

    modport master (
        output rx_data, rx_valid, frame_err, number, number_valid, state
    );

    modport slave (
        input rx_data, rx_valid, frame_err, number, number_valid, state
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizes the serial line, finds the start bit,
// samples each bit in its middle and checks the stop bit.
module uart_rx_byte
    import uart_number_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      usb_rx,
    output logic [7:0] rx_data,
    output logic      rx_valid,
    output logic      frame_err,
    output rx_state_t state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] sample_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_byte;

    // Two-flop synchronizer; resets to the idle level so leaving reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= usb_rx;
            sync_2 <= sync_1;
        end
    end

    // Byte FSM with registered data and single-cycle strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_byte <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    bit_cnt    <= '0;
                    if (!sync_2) state <= START;
                end
                START: begin
                    // Re-check the line half a bit later to reject glitches.
                    if (sample_cnt == HALF_LAST) begin
                        sample_cnt <= '0;
                        state      <= sync_2 ? IDLE : DATA;
                    end else begin
                        sample_cnt <= sample_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (sample_cnt == FULL_LAST) begin
                        sample_cnt <= '0;
                        shift_byte <= {sync_2, shift_byte[7:1]};
                        if (bit_cnt == 3'd7) state <= STOP;
                        else bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        sample_cnt <= sample_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (sample_cnt == FULL_LAST) begin
                        sample_cnt <= '0;
                        if (sync_2) begin
                            rx_data  <= shift_byte;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // Break condition: ignore the line until it returns high.
                    if (sync_2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_number_rx.sv
// Serial decimal-number receiver: bytes from uart_rx_byte are assembled into
// a BCD shift register and committed to 'number' on carriage return.
module uart_number_rx
    import uart_number_rx_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int BAUD_RATE                   = 1_000_000,
    parameter int NUMBER_OF_DIGITS            = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               usb_rx,
    uart_number_rx_if.master   bus
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(BOARD_CLOCK_FREQUENCY_IN_HZ, BAUD_RATE);
    localparam int NW           = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
    localparam int BPD          = NUMBER_OF_BITS_PER_DIGIT;
    localparam int CNT_W        = $clog2(NUMBER_OF_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUMBER_OF_DIGITS);

    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ferr;
    rx_state_t        byte_state;

    logic [NW-1:0]    shift_reg;
    logic [NW-1:0]    number_r;
    logic             number_valid_r;
    logic [CNT_W-1:0] digit_cnt;
    logic             is_digit;
    logic [7:0]       digit_off;
    logic [BPD-1:0]   digit_val;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk      (clk),
        .rst      (rst),
        .usb_rx   (usb_rx),
        .rx_data  (byte_data),
        .rx_valid (byte_valid),
        .frame_err(byte_ferr),
        .state    (byte_state)
    );

    // Classify the received byte and extract its BCD value.
    always_comb begin
        is_digit  = (byte_data >= ASCII_ZERO) && (byte_data <= ASCII_NINE);
        digit_off = byte_data - ASCII_ZERO;
        digit_val = digit_off[BPD-1:0];
    end

    // Digit assembly: shift in digits, commit on CR, clear on anything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg      <= '0;
            digit_cnt      <= '0;
            number_r       <= '0;
            number_valid_r <= 1'b0;
        end else begin
            number_valid_r <= 1'b0;
            if (byte_ferr) begin
                shift_reg <= '0;
                digit_cnt <= '0;
            end else if (byte_valid) begin
                if (is_digit) begin
                    // Oldest digit falls off the top once the register is full.
                    shift_reg <= (shift_reg << BPD) | NW'(digit_val);
                    if (digit_cnt != CNT_MAX) digit_cnt <= digit_cnt + CNT_W'(1);
                end else if (byte_data == ASCII_CR) begin
                    if (digit_cnt != '0) begin
                        number_r       <= shift_reg;
                        number_valid_r <= 1'b1;
                    end
                    shift_reg <= '0;
                    digit_cnt <= '0;
                end else begin
                    shift_reg <= '0;
                    digit_cnt <= '0;
                end
            end
        end
    end

    assign bus.rx_data      = byte_data;
    assign bus.rx_valid     = byte_valid;
    assign bus.frame_err    = byte_ferr;
    assign bus.number       = number_r;
    assign bus.number_valid = number_valid_r;
    assign bus.state        = byte_state;

endmodule

// File: tb/tb_uart_number_rx.sv
// Directed bench for uart_number_rx at 100 clocks per bit.
module tb_uart_number_rx;
    import uart_number_rx_pkg::*;

    localparam int CPB = 100;
    localparam int GAP = 20;

    logic clk = 1'b0;
    logic rst;
    logic usb_rx;

    uart_number_rx_if #(.NUMBER_W(16)) bus ();

    uart_number_rx dut (
        .clk   (clk),
        .rst   (rst),
        .usb_rx(usb_rx),
        .bus   (bus)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cnt_rx = 0;
    int cnt_fe = 0;
    int cnt_nv = 0;
    logic [7:0] exp_q[$];
    logic prev_rv = 1'b0;
    logic prev_fe = 1'b0;
    logic prev_nv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Driver: one 8N1 frame, LSB first; good frames are queued for the scoreboard.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) exp_q.push_back(b);
        usb_rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            usb_rx = b[i];
            wait_cyc(CPB);
        end
        usb_rx = stop_bit;
        wait_cyc(CPB);
        if (stop_bit) wait_cyc(GAP);
    endtask

    task automatic clear_counts();
        cnt_rx = 0;
        cnt_fe = 0;
        cnt_nv = 0;
    endtask

    // Scoreboard and strobe-shape monitor
    always @(negedge clk) begin
        if (!rst && (bus.rx_valid || bus.frame_err || bus.number_valid)) begin
            check("pulse_overlap", 32'(bus.rx_valid) + 32'(bus.frame_err) + 32'(bus.number_valid), 1);
            check("pulse_width", {29'd0, prev_rv & bus.rx_valid, prev_fe & bus.frame_err,
                                  prev_nv & bus.number_valid}, 0);
        end
        if (bus.rx_valid) begin
            cnt_rx++;
            if (exp_q.size() == 0) check("rx_unexpected", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
            else check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (bus.frame_err)    cnt_fe++;
        if (bus.number_valid) cnt_nv++;
        prev_rv = bus.rx_valid;
        prev_fe = bus.frame_err;
        prev_nv = bus.number_valid;
    end

    typedef struct {
        string       text;
        int          exp_rx;
        int          exp_nv;
        logic [15:0] exp_num;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"1234\015",  5, 1, 16'h1234};
        vecs[1] = '{"98765\015", 6, 1, 16'h8765};
        vecs[2] = '{"12\015",    3, 1, 16'h0012};
        vecs[3] = '{"12x3\015",  5, 1, 16'h0003};
        vecs[4] = '{"\015",      1, 0, 16'h0003};
        vecs[5] = '{"9\015",     2, 1, 16'h0009};
        vecs[6] = '{"x\015",     2, 0, 16'h0009};

        rst    = 1'b1;
        usb_rx = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(5);

        // Reset state
        check("reset_rx_data", {24'd0, bus.rx_data}, 0);
        check("reset_number", {16'd0, bus.number}, 0);
        check("reset_strobes", {29'd0, bus.rx_valid, bus.frame_err, bus.number_valid}, 0);
        check("reset_state", {29'd0, bus.state}, {29'd0, IDLE});

        // Table-driven byte strings
        for (int v = 0; v < 7; v++) begin
            clear_counts();
            for (int i = 0; i < vecs[v].text.len(); i++) send_byte(vecs[v].text[i], 1'b1);
            wait_cyc(GAP);
            check($sformatf("v%0d_rx_count", v), cnt_rx, vecs[v].exp_rx);
            check($sformatf("v%0d_fe_count", v), cnt_fe, 0);
            check($sformatf("v%0d_nv_count", v), cnt_nv, vecs[v].exp_nv);
            check($sformatf("v%0d_number", v), {16'd0, bus.number}, {16'd0, vecs[v].exp_num});
            check($sformatf("v%0d_queue", v), exp_q.size(), 0);
        end

        // Short low glitch must be rejected, then a normal byte follows.
        clear_counts();
        usb_rx = 1'b0;
        wait_cyc(30);
        usb_rx = 1'b1;
        wait_cyc(200);
        check("glitch_rx", cnt_rx, 0);
        check("glitch_fe", cnt_fe, 0);
        send_byte(8'h41, 1'b1);
        wait_cyc(GAP);
        check("glitch_next_rx", cnt_rx, 1);
        check("glitch_next_data", {24'd0, bus.rx_data}, 32'h41);
        check("glitch_number_kept", {16'd0, bus.number}, 32'h0009);

        // Framing error followed by a held break, then recovery.
        clear_counts();
        send_byte(8'h31, 1'b0);
        wait_cyc(250);
        check("break_state", {29'd0, bus.state}, {29'd0, WAIT_HIGH});
        wait_cyc(250);
        usb_rx = 1'b1;
        wait_cyc(50);
        check("break_fe", cnt_fe, 1);
        check("break_rx", cnt_rx, 0);
        send_byte("5", 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_cyc(GAP);
        check("break_fe_total", cnt_fe, 1);
        check("break_number", {16'd0, bus.number}, 32'h0005);
        check("break_nv", cnt_nv, 1);

        // Reset in the middle of a frame after a pending digit.
        clear_counts();
        send_byte("4", 1'b1);
        usb_rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            usb_rx = 1'b1;
            wait_cyc(CPB);
        end
        usb_rx = 1'b0;
        wait_cyc(50);
        rst    = 1'b1;
        usb_rx = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(2);
        check("rst_rx_data", {24'd0, bus.rx_data}, 0);
        check("rst_number", {16'd0, bus.number}, 0);
        check("rst_strobes", {29'd0, bus.rx_valid, bus.frame_err, bus.number_valid}, 0);
        check("rst_state", {29'd0, bus.state}, {29'd0, IDLE});
        wait_cyc(200);
        check("rst_no_spurious", cnt_rx, 1);
        send_byte("8", 1'b1);
        send_byte(8'h0D, 1'b1);
        wait_cyc(GAP);
        check("rst_number_after", {16'd0, bus.number}, 32'h0008);
        check("rst_nv", cnt_nv, 1);
        check("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_number_rx.md
UART_NUMBER_RX -- requirements
Module: uart_number_rx

Interface
REQ-001 Parameter: BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000, clk frequency.
REQ-002 Parameter: BAUD_RATE, default 1_000_000, serial bit rate; CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE (integer, >= 8).
REQ-003 Parameter: NUMBER_OF_DIGITS, default 4, BCD digits assembled.
REQ-004 Parameter: NUMBER_OF_BITS_PER_DIGIT, default 4, bits per BCD digit.
REQ-005 Port: clk, input, 1, the only clock; all logic rising-edge.
REQ-006 Port: rst, input, 1, synchronous active-high reset.
REQ-007 Port: usb_rx, input, 1, asynchronous serial line (8N1, idle high).
REQ-008 Port: rx_data, output, 8, last correctly framed byte.
REQ-009 Port: rx_valid, output, 1, one-cycle pulse when rx_data updates.
REQ-010 Port: frame_err, output, 1, one-cycle pulse on a low stop bit.
REQ-011 Port: number, output, NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT, committed BCD value (digit 0 in LSBs).
REQ-012 Port: number_valid, output, 1, one-cycle pulse when number updates.

Function
REQ-013 usb_rx shall pass through a 2-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-014 Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE -> START on synchronized line low; the bit counter is cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles, line sampled; low -> DATA, high -> IDLE (glitch rejected, no outputs).
REQ-017 DATA: 8 samples, each CLKS_PER_BIT cycles apart, LSB first, then -> STOP.
REQ-018 STOP: sample after CLKS_PER_BIT cycles; high -> rx_data loaded, rx_valid pulsed next cycle, -> IDLE; low -> frame_err pulsed next cycle, -> WAIT_HIGH.
REQ-019 WAIT_HIGH -> IDLE only once the line is high; no start detection is allowed while low (break condition).
REQ-020 Digit assembly, on each rx_valid: byte 0x30..0x39 -> shift register shifts left one digit and inserts (byte - 0x30); digit count saturates at NUMBER_OF_DIGITS, oldest digit discarded.
REQ-021 Byte 0x0D (CR) with count >= 1 -> number loads the zero-extended shift register, number_valid pulses the cycle after rx_valid, and the shift register and count clear.
REQ-022 CR with count == 0 -> no update and no pulse.
REQ-023 Any other byte, or a frame_err, -> shift register and count clear; number is unchanged.
REQ-024 number holds its value between commits; rx_valid, frame_err and number_valid are never high together, nor for more than one cycle.

Reset
REQ-025 rst, sampled on clk, forces IDLE and clears the bit counter, the sample counter, the shift register and the digit count; rx_data = 0, number = 0, and rx_valid = frame_err = number_valid = 0.
REQ-026 rst takes effect mid-byte; the partial byte is discarded and the next falling edge after rst deasserts starts a new frame.
REQ-027 Synchronizer flops shall reset to 1 (idle) so that deasserting rst produces no false start.

Structure
REQ-028 Shared package: FSM state encoding, ASCII constants (0x30, 0x39, 0x0D), and the CLKS_PER_BIT function.
REQ-029 One sub-module, uart_rx_byte (REQ-013..019), shall be instantiated by uart_number_rx, which adds the digit assembly (REQ-020..024).

Verification (defaults, CLKS_PER_BIT = 100)
REQ-030 Send "1234" then CR -> four rx_valid pulses plus one for CR; number = 0x1234; exactly one number_valid.
REQ-031 Send "98765" then CR -> number = 0x8765; send "12" then CR -> number = 0x0012.
REQ-032 Send "12x3" then CR -> number = 0x0003; send CR alone -> no number_valid, number unchanged.
REQ-033 Drive a 30-cycle low glitch on usb_rx -> no rx_valid and no frame_err; the next byte 0x41 is received correctly.
REQ-034 Send 0x31 with stop bit low, hold line low 500 cycles, then send "5" and CR -> one frame_err, none retriggered during the hold, number = 0x0005.
REQ-035 Assert rst for 1 cycle during bit 3 of "7", then send "8" and CR -> all outputs 0 after rst, then number = 0x0008.
